video_lock_controller: RTL and testbench

- Sequences the sync-processing chain between hsync activity detection and the monitor interface.
- Holds the polarity detectors in reset while no signal is present, then waits for them to settle.
- Qualifies the video format code over several consecutive frames before publishing it.
- Publishes a stable locked format and valid flag, so format, Y/G normalisation and output-enable decisions never act on transient detector codes.

---
 rtl/vlc_pkg.sv | 24 ++
 rtl/sync_fall_detect.sv | 25 ++
 rtl/video_lock_controller.sv | 185 ++++++++++++++++++
 tb/tb_video_lock_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_pkg.sv
// Shared definitions for the video lock controller: lock_state encoding,
// the unknown-format code, default timing constants and a counter-width helper.
package vlc_pkg;

    typedef enum logic [1:0] {
        NO_SIGNAL = 2'd0,
        SETTLE    = 2'd1,
        MEASURE   = 2'd2,
        LOCKED    = 2'd3
    } lock_state_t;

    localparam int unsigned FORMAT_UNKNOWN    = 0;

    localparam int unsigned DEF_SETTLE_CYCLES = 2500000;
    localparam int unsigned DEF_STABLE_FRAMES = 4;
    localparam int unsigned DEF_LOSS_TIMEOUT  = 5000000;
    localparam int unsigned DEF_FMT_W         = 8;

    // Never return a zero width, so limits of 1 still get a real register.
    function automatic int unsigned cnt_w(input int unsigned limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/sync_fall_detect.sv
// 2-FF synchroniser followed by a registered falling-edge strobe.
// Strobe is high for one cycle, three clocks after the pin falls.
module sync_fall_detect #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset_x,
    input  logic async_in,
    output logic fall_strobe
);

    // sh_q[0], sh_q[1] synchronise; sh_q[2] is the previous synchronised value.
    logic [2:0] sh_q;

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            sh_q        <= {3{IDLE_LEVEL}};
            fall_strobe <= 1'b0;
        end else begin
            sh_q        <= {sh_q[1:0], async_in};
            fall_strobe <= sh_q[2] & ~sh_q[1];
        end
    end

endmodule

// File: rtl/video_lock_controller.sv
// Sequences detector reset, settle time and multi-frame format qualification.
// Optional: define VLC_GLITCH_HOLD_EN to tolerate one mismatching sample while locked.
module video_lock_controller
    import vlc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned STABLE_FRAMES = DEF_STABLE_FRAMES,
    parameter int unsigned LOSS_TIMEOUT  = DEF_LOSS_TIMEOUT,
    parameter int unsigned FMT_W         = DEF_FMT_W
) (
    input  logic             clk_50mhz_in,
    input  logic             reset_x,
    input  logic             signal_present,
    input  logic             vsync_in_x,
    input  logic [FMT_W-1:0] video_format,
    output logic             det_reset,
    output logic             format_valid,
    output logic [FMT_W-1:0] locked_format,
    output logic             relock_pulse,
    output logic [1:0]       lock_state
);

    localparam int unsigned SW = cnt_w(SETTLE_CYCLES);
    localparam int unsigned MW = cnt_w(STABLE_FRAMES + 1);
    localparam int unsigned LW = cnt_w(LOSS_TIMEOUT);

    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0]    MATCH_LOCK  = MW'(STABLE_FRAMES);
    localparam logic [LW-1:0]    LOSS_LAST   = LW'(LOSS_TIMEOUT - 1);
    localparam logic [FMT_W-1:0] FMT_UNK     = FMT_W'(FORMAT_UNKNOWN);

    lock_state_t      state_q, state_n;
    logic [SW-1:0]    settle_q, settle_n;
    logic [MW-1:0]    match_q, match_n;
    logic [LW-1:0]    loss_q, loss_n;
    logic [FMT_W-1:0] cand_q, cand_n;
    logic [FMT_W-1:0] lockf_q, lockf_n;
    logic             det_q, det_n;
    logic             valid_q, valid_n;
    logic             pulse_q, pulse_n;
    logic             relock;
    logic             vs_evt;
`ifdef VLC_GLITCH_HOLD_EN
    logic             miss_q, miss_n;
`endif

    sync_fall_detect #(
        .IDLE_LEVEL (1'b1)
    ) u_vsync_fall (
        .clk         (clk_50mhz_in),
        .reset_x     (reset_x),
        .async_in    (vsync_in_x),
        .fall_strobe (vs_evt)
    );

    always_ff @(posedge clk_50mhz_in) begin
        if (!reset_x) begin
            state_q  <= NO_SIGNAL;
            settle_q <= '0;
            match_q  <= '0;
            loss_q   <= '0;
            cand_q   <= '0;
            lockf_q  <= '0;
            det_q    <= 1'b1;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
`ifdef VLC_GLITCH_HOLD_EN
            miss_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            settle_q <= settle_n;
            match_q  <= match_n;
            loss_q   <= loss_n;
            cand_q   <= cand_n;
            lockf_q  <= lockf_n;
            det_q    <= det_n;
            valid_q  <= valid_n;
            pulse_q  <= pulse_n;
`ifdef VLC_GLITCH_HOLD_EN
            miss_q   <= miss_n;
`endif
        end
    end

    always_comb begin
        state_n  = state_q;
        settle_n = settle_q;
        match_n  = match_q;
        loss_n   = loss_q;
        cand_n   = cand_q;
        lockf_n  = lockf_q;
        pulse_n  = 1'b0;
        relock   = 1'b0;
`ifdef VLC_GLITCH_HOLD_EN
        miss_n   = miss_q;
`endif

        case (state_q)
            NO_SIGNAL: begin
                if (signal_present) begin
                    state_n  = SETTLE;
                    settle_n = '0;
                end
            end

            SETTLE: begin
                if (!signal_present) begin
                    state_n = NO_SIGNAL;
                end else if (settle_q == SETTLE_LAST) begin
                    state_n = MEASURE;
                    match_n = '0;
                    cand_n  = '0;
                    loss_n  = '0;
                end else if (settle_q != '1) begin
                    settle_n = settle_q + SW'(1);
                end
            end

            MEASURE, LOCKED: begin
                // Signal loss outranks the watchdog, which outranks the vsync event.
                if (!signal_present || loss_q == LOSS_LAST) begin
                    state_n = NO_SIGNAL;
                    pulse_n = (state_q == LOCKED);
                end else begin
                    if (vs_evt)
                        loss_n = '0;
                    else if (loss_q != '1)
                        loss_n = loss_q + LW'(1);

                    if (vs_evt && state_q == MEASURE) begin
                        if (video_format == FMT_UNK) begin
                            match_n = '0;
                        end else if (video_format == cand_q) begin
                            if (match_q != '1)
                                match_n = match_q + MW'(1);
                        end else begin
                            cand_n  = video_format;
                            match_n = MW'(1);
                        end
                        if (match_n >= MATCH_LOCK) begin
                            state_n = LOCKED;
                            lockf_n = cand_n;
`ifdef VLC_GLITCH_HOLD_EN
                            miss_n  = 1'b0;
`endif
                        end
                    end else if (vs_evt && state_q == LOCKED) begin
                        if (video_format != lockf_q) begin
`ifdef VLC_GLITCH_HOLD_EN
                            relock = miss_q;
                            miss_n = ~miss_q;
`else
                            relock = 1'b1;
`endif
                        end else begin
`ifdef VLC_GLITCH_HOLD_EN
                            miss_n = 1'b0;
`endif
                        end
                    end

                    if (relock) begin
                        state_n = MEASURE;
                        pulse_n = 1'b1;
                        cand_n  = video_format;
                        match_n = (video_format != FMT_UNK) ? MW'(1) : '0;
                    end
                end
            end

            default: state_n = NO_SIGNAL;
        endcase

        det_n   = (state_n == NO_SIGNAL);
        valid_n = (state_n == LOCKED);
    end

    assign det_reset     = det_q;
    assign format_valid  = valid_q;
    assign locked_format = lockf_q;
    assign relock_pulse  = pulse_q;
    assign lock_state    = state_q;

endmodule

// File: tb/tb_video_lock_controller.sv
// Self-checking bench for video_lock_controller: directed frame tables, corner
// sequences and randomized stimulus against a queue-based reference model.
module tb_video_lock_controller;

    localparam int SETTLE = 16;
    localparam int STABLE = 3;
    localparam int LOSS   = 200;
`ifdef VLC_GLITCH_HOLD_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_x = 1'b0;
    logic       signal_present = 1'b0;
    logic       vsync_in_x = 1'b1;
    logic [7:0] video_format = 8'h00;
    logic       det_reset;
    logic       format_valid;
    logic [7:0] locked_format;
    logic       relock_pulse;
    logic [1:0] lock_state;

    always #10 clk = ~clk;

    video_lock_controller #(
        .SETTLE_CYCLES (SETTLE),
        .STABLE_FRAMES (STABLE),
        .LOSS_TIMEOUT  (LOSS),
        .FMT_W         (8)
    ) dut (
        .clk_50mhz_in   (clk),
        .reset_x        (reset_x),
        .signal_present (signal_present),
        .vsync_in_x     (vsync_in_x),
        .video_format   (video_format),
        .det_reset      (det_reset),
        .format_valid   (format_valid),
        .locked_format  (locked_format),
        .relock_pulse   (relock_pulse),
        .lock_state     (lock_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase number, elapsed-cycle counters, recent-sample history.
    int         m_mode;
    bit         m_det, m_valid, m_pulse, m_miss;
    logic [7:0] m_lf;
    int         m_since, m_since_evt;
    logic [7:0] m_hist[$];
    bit         m_pin[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit stable_run();
        if (m_hist.size() < STABLE) return 1'b0;
        for (int i = m_hist.size() - STABLE; i < m_hist.size(); i++)
            if (m_hist[i] == 8'h00 || m_hist[i] != m_hist[m_hist.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_det = 1'b1; m_valid = 1'b0; m_pulse = 1'b0; m_miss = 1'b0;
        m_lf = 8'h00; m_since = 0; m_since_evt = 0;
        m_hist.delete();
        m_pin.delete();
        for (int i = 0; i < 4; i++) m_pin.push_back(1'b1);
    endtask

    task automatic model_step(input bit sp, input bit rst, input bit pin, input logic [7:0] s);
        bit evt;
        if (!rst) begin
            model_reset();
            return;
        end
        // Event seen at this edge: pin sampled high four edges ago, low three edges ago.
        evt = m_pin[0] && !m_pin[1];
        void'(m_pin.pop_front());
        m_pin.push_back(pin);
        m_pulse = 1'b0;
        case (m_mode)
            0: if (sp) begin m_mode = 1; m_since = 0; end
            1: begin
                if (!sp) m_mode = 0;
                else if (m_since == SETTLE - 1) begin
                    m_mode = 2; m_hist.delete(); m_since_evt = 0;
                end else m_since++;
            end
            default: begin
                if (!sp || m_since_evt == LOSS - 1) begin
                    m_pulse = (m_mode == 3);
                    m_mode  = 0;
                end else begin
                    m_since_evt = evt ? 0 : m_since_evt + 1;
                    if (evt && m_mode == 2) begin
                        m_hist.push_back(s);
                        if (m_hist.size() > STABLE) void'(m_hist.pop_front());
                        if (stable_run()) begin m_mode = 3; m_lf = s; m_miss = 1'b0; end
                    end else if (evt) begin
                        if (s == m_lf) m_miss = 1'b0;
                        else if (GLITCH && !m_miss) m_miss = 1'b1;
                        else begin
                            m_pulse = 1'b1; m_mode = 2; m_miss = 1'b0;
                            m_hist.delete(); m_hist.push_back(s);
                        end
                    end
                end
            end
        endcase
        m_det   = (m_mode == 0);
        m_valid = (m_mode == 3);
    endtask

    task automatic tick(input bit sp, input bit rst, input bit pin, input logic [7:0] f);
        @(negedge clk);
        reset_x = rst; signal_present = sp; vsync_in_x = pin; video_format = f;
        model_step(sp, rst, pin, f);
        @(posedge clk);
        #1;
        check("model", int'({lock_state, det_reset, format_valid, locked_format, relock_pulse}),
              int'({2'(m_mode), m_det, m_valid, m_lf, m_pulse}));
    endtask

    task automatic frame(input logic [7:0] f, output int pulses);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1'b1, 1'b1, (i >= 5), f);
            pulses += int'(relock_pulse);
        end
    endtask

    typedef struct {
        logic [7:0] fmt;
        int         st;
        int         valid;
        logic [7:0] lf;
        int         pulses;
    } frame_vec_t;

    frame_vec_t vecs[$];

    function automatic void add(input logic [7:0] f, input int st, input int v,
                                input logic [7:0] lf, input int p);
        frame_vec_t r;
        r.fmt = f; r.st = st; r.valid = v; r.lf = lf; r.pulses = p;
        vecs.push_back(r);
    endfunction

    initial begin
        int         pulses, n;
        bit         sp, rst, pin;
        int         phase, period;
        logic [7:0] cur;
        logic [7:0] pool [4];

        model_reset();

        // Reset values
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 8'h00);
        check("rst_state", lock_state, 0);
        check("rst_det", det_reset, 1);
        check("rst_valid", format_valid, 0);
        check("rst_lf", locked_format, 0);
        check("rst_pulse", relock_pulse, 0);

        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b1, 1'b1, 8'h07);
            check("idle", int'({lock_state, det_reset, format_valid}), int'({2'd0, 1'b1, 1'b0}));
        end

        // Settle window
        tick(1'b1, 1'b1, 1'b1, 8'h07);
        check("settle_det", det_reset, 0);
        check("settle_enter", lock_state, 1);
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b1, 8'h07);
        check("settle_hold", lock_state, 1);
        tick(1'b1, 1'b1, 1'b1, 8'h07);
        check("measure_enter", lock_state, 2);

        // Frame table: sample, then state/valid/locked_format/pulse count after the frame
        add(8'h07, 2, 0, 8'h00, 0);
        add(8'h07, 2, 0, 8'h00, 0);
        add(8'h07, 3, 1, 8'h07, 0);
        if (GLITCH) begin
            add(8'h03, 3, 1, 8'h07, 0);
            add(8'h07, 3, 1, 8'h07, 0);
            add(8'h03, 3, 1, 8'h07, 0);
            add(8'h03, 2, 0, 8'h07, 1);
        end else begin
            add(8'h03, 2, 0, 8'h07, 1);
        end
        add(8'h07, 2, 0, 8'h07, 0);
        add(8'h07, 2, 0, 8'h07, 0);
        add(8'h05, 2, 0, 8'h07, 0);
        add(8'h05, 2, 0, 8'h07, 0);
        add(8'h05, 3, 1, 8'h05, 0);
        if (GLITCH) add(8'h00, 3, 1, 8'h05, 0);
        add(8'h00, 2, 0, 8'h05, 1);
        add(8'h00, 2, 0, 8'h05, 0);
        add(8'h09, 2, 0, 8'h05, 0);
        add(8'h09, 2, 0, 8'h05, 0);
        add(8'h09, 3, 1, 8'h09, 0);

        foreach (vecs[i]) begin
            frame(vecs[i].fmt, pulses);
            check($sformatf("vec%0d_state", i), lock_state, vecs[i].st);
            check($sformatf("vec%0d_valid", i), format_valid, vecs[i].valid);
            check($sformatf("vec%0d_lf", i), locked_format, vecs[i].lf);
            check($sformatf("vec%0d_pulse", i), pulses, vecs[i].pulses);
        end

        // Watchdog: one last event, then vsync stops
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 8'h09);
        pulses = 0;
        for (n = 1; n <= 400; n++) begin
            tick(1'b1, 1'b1, 1'b1, 8'h09);
            pulses += int'(relock_pulse);
            if (lock_state == 2'd0) break;
        end
        check("wd_cycles", n, 200);
        check("wd_pulse", pulses, 1);

        // Lock on 0A, then drop signal_present on the event cycle
        for (int i = 0; i < 17; i++) tick(1'b1, 1'b1, 1'b1, 8'h0A);
        for (int i = 0; i < 3; i++) frame(8'h0A, pulses);
        check("relock_0a", int'({lock_state, locked_format}), int'({2'd3, 8'h0A}));
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 8'h0B);
        tick(1'b0, 1'b1, 1'b0, 8'h0B);
        check("drop_state", lock_state, 0);
        check("drop_valid", format_valid, 0);
        check("drop_pulse", relock_pulse, 1);
        check("drop_lf", locked_format, 8'h0A);
        tick(1'b0, 1'b1, 1'b1, 8'h0B);
        check("drop_pulse_end", relock_pulse, 0);

        // Reset in the middle of SETTLE
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b1, 8'h0A);
        tick(1'b1, 1'b0, 1'b1, 8'h0A);
        check("mid_rst", int'({lock_state, det_reset, format_valid, locked_format, relock_pulse}),
              int'({2'd0, 1'b1, 1'b0, 8'h00, 1'b0}));
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, 1'b1, 8'h0A);
        check("mid_rst_settle", lock_state, 1);
        tick(1'b1, 1'b1, 1'b1, 8'h0A);
        check("mid_rst_measure", lock_state, 2);

        // Randomized run against the model
        pool[0] = 8'h00; pool[1] = 8'h03; pool[2] = 8'h05; pool[3] = 8'h07;
        sp = 1'b1; phase = 10; period = 50; cur = 8'h07;
        for (int c = 0; c < 20000; c++) begin
            rst = ($urandom_range(0, 1999) != 0);
            if ($urandom_range(0, 299) == 0) sp = ~sp;
            pin = (phase >= 3);
            phase++;
            if (phase >= period) begin
                phase  = 0;
                period = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 300))
                                                     : int'($urandom_range(8, 80));
                if ($urandom_range(0, 3) == 0) cur = pool[$urandom_range(0, 3)];
            end
            tick(sp, rst, pin, cur);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
